// File: rtl/byte_stripe_pkg.sv
// Shared definitions for the byte striping / un-striping pair: default widths,
// lane indices and the per-lane byte counter width.
package byte_stripe_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_HOLD  = 2;
    localparam int unsigned CNT_W     = 8;

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_e;

endpackage

// File: rtl/stripe_lane.sv
// One striping lane: data register, valid flag stretched by a hold counter,
// and a wrapping count of bytes written.
module stripe_lane
    import byte_stripe_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned HOLD  = DEF_HOLD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned     HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0]   HOLD_LOAD = HW'(HOLD - 1);

    logic [HW-1:0] hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            data  <= '0;
            valid <= 1'b0;
            hold  <= '0;
            count <= '0;
        end else if (wr_en) begin
            data  <= wr_data;
            valid <= 1'b1;
            hold  <= HOLD_LOAD;
            count <= count + 1'b1;
        end else if (hold != '0) begin
            // data is never cleared; only the qualifier times out
            hold  <= hold - 1'b1;
            valid <= 1'b1;
        end else begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/byte_striping.sv
// Distributes a serial byte stream alternately over two lanes; flush realigns
// the lane pointer so the next byte lands on lane 0.
module byte_striping
    import byte_stripe_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned HOLD  = DEF_HOLD
) (
    input  logic             clk_2f,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    input  logic             flush,
    output logic [WIDTH-1:0] lane_0,
    output logic [WIDTH-1:0] lane_1,
    output logic             valid_0,
    output logic             valid_1,
    output logic [CNT_W-1:0] count_0,
    output logic [CNT_W-1:0] count_1
);

    lane_e sel;
    lane_e sel_next;
    logic  wr_en_0;
    logic  wr_en_1;

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            sel <= LANE0;
        end else begin
            sel <= sel_next;
        end
    end

    // A flushed write is forced onto lane 0, so the following byte goes to lane 1.
    always_comb begin
        sel_next = sel;
        wr_en_0  = 1'b0;
        wr_en_1  = 1'b0;
        if (valid_in) begin
            if (flush || (sel == LANE0)) begin
                wr_en_0  = 1'b1;
                sel_next = LANE1;
            end else begin
                wr_en_1  = 1'b1;
                sel_next = LANE0;
            end
        end else if (flush) begin
            sel_next = LANE0;
        end
    end

    stripe_lane #(
        .WIDTH (WIDTH),
        .HOLD  (HOLD)
    ) u_lane_0 (
        .clk     (clk_2f),
        .reset   (reset),
        .wr_en   (wr_en_0),
        .wr_data (data_in),
        .data    (lane_0),
        .valid   (valid_0),
        .count   (count_0)
    );

    stripe_lane #(
        .WIDTH (WIDTH),
        .HOLD  (HOLD)
    ) u_lane_1 (
        .clk     (clk_2f),
        .reset   (reset),
        .wr_en   (wr_en_1),
        .wr_data (data_in),
        .data    (lane_1),
        .valid   (valid_1),
        .count   (count_1)
    );

endmodule
